ex_branch_resolve: RTL and testbench
====================================

EX_BRANCH_RESOLVE -- requirements
Module: ex_branch_resolve

Interface
REQ-001 Port clk, input, 1, rising-edge clock for all state.
REQ-002 Port rst, input, 1, synchronous active-high reset, sampled on clk rising edge.
REQ-003 Port pipeline_en, input, 1, EX instruction advances this cycle.
REQ-004 Port ex_forward_pipeline_flush / ex_invalid_inst, input, 1 each, EX slot holds a flush bubble / illegal instruction.
REQ-005 Port ex_pc, ex_op1, ex_op2, ex_immediate, input, 32 each, EX PC, forwarded rs1/rs2 values, immediate.
REQ-006 Port ex_opcode, input, 7; ex_func3, input, 3; instruction fields.
REQ-007 Port ex_pred_valid, ex_pred_taken, input, 1 each; ex_predicted_pc, input, 32; BTB prediction carried with the instruction.
REQ-008 Port redirect_valid, output, 1; redirect_pc, output, 32; registered fetch redirect and flush request.
REQ-009 Port btb_upd_valid, btb_upd_taken, output, 1 each; btb_upd_pc, btb_upd_target, output, 32 each; registered BTB update.
REQ-010 Port branch_cnt, mispredict_cnt, output, 32 each; performance counters.

Function
REQ-011 Resolution SHALL occur only in a qualifying cycle: pipeline_en=1, state RESOLVE, ex_forward_pipeline_flush=0, ex_invalid_inst=0.
REQ-012 Control instruction: opcode 1100011 (branch), 1101111 (JAL), 1100111 (JALR); all others non-control.
REQ-013 Branch taken per func3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 SHALL be not-taken; JAL/JALR always taken.
REQ-014 Target: branch/JAL = ex_pc+ex_immediate; JALR = (ex_op1+ex_immediate) with bit 0 cleared; all sums modulo 2^32 (wrap, no overflow flag).
REQ-015 Actual next PC = target if taken, else ex_pc+4 (modulo 2^32).
REQ-016 Predicted next PC = ex_predicted_pc if ex_pred_valid&ex_pred_taken, else ex_pc+4.
REQ-017 Mispredict = predicted next PC != actual next PC; applies to non-control instructions too (BTB alias).
REQ-018 On qualifying mispredict, redirect_valid SHALL be 1 for exactly the next cycle with redirect_pc = actual next PC; otherwise 0.
REQ-019 On qualifying control instruction, btb_upd_valid SHALL be 1 for exactly the next cycle with btb_upd_pc=ex_pc, btb_upd_target=target, btb_upd_taken=taken; non-control alias SHALL update with taken=0, target=ex_pc+4.
REQ-020 FSM states RESOLVE, SHADOW: RESOLVE->SHADOW on qualifying mispredict; SHADOW->RESOLVE on first cycle with pipeline_en=1; SHADOW holds while pipeline_en=0.
REQ-021 In SHADOW the EX instruction is wrong-path: no redirect, no BTB update, no counting.
REQ-022 Stall (pipeline_en=0) SHALL produce no resolution, so a stalled instruction is resolved and counted exactly once.
REQ-023 redirect_pc, btb_upd_* SHALL hold last value when their valid is 0.
REQ-024 branch_cnt +1 per qualifying control instruction; mispredict_cnt +1 per qualifying mispredict (both in same cycle allowed); counters wrap 0xFFFFFFFF->0.

Reset
REQ-025 rst SHALL take priority over all inputs, including mid-SHADOW and mid-stall.
REQ-026 Reset values: all outputs 0, counters 0, state RESOLVE; first resolution possible the cycle after rst deasserts.

Configuration
REQ-027 Macro BRANCH_PERF_CNT_EN: defined -> counters per REQ-024; undefined -> counter registers absent, branch_cnt and mispredict_cnt tied to 0; all other behaviour identical.

Verification
REQ-028 BEQ pc=0x100, imm=0x20, op1=op2=5, pred none -> next cycle redirect_valid=1, redirect_pc=0x120, btb_upd_target=0x120, taken=1, mispredict_cnt=1.
REQ-029 BNE pc=0x200, op1=op2, pred_valid=1 taken=1 predicted_pc=0x240 -> redirect_pc=0x204, btb_upd_taken=0; following wrong-path instruction ignored (SHADOW).
REQ-030 JALR op1=0x1001, imm=0x2, correctly predicted 0x1002 -> redirect_valid=0, btb_upd_valid=1, target=0x1002, branch_cnt+1.
REQ-031 BLT op1=0xFFFFFFFF, op2=1 held with pipeline_en=0 for 3 cycles then 1 -> taken, counted once, single redirect pulse after release.
REQ-032 ADDI at pc=0x300 with pred taken to 0x400 -> redirect_pc=0x304, btb_upd_taken=0, branch_cnt unchanged.
REQ-033 rst asserted in SHADOW -> next cycle state RESOLVE, all outputs 0; macro undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: EX-stage branch resolution, mispredict redirect, BTB update and perf counters
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pipeline_en               EX instruction advances this cycle
//   ex_forward_pipeline_flush EX slot is a flush bubble
//   ex_invalid_inst           EX slot is an illegal instruction
//   ex_pc/op1/op2/immediate   EX PC, forwarded rs1/rs2, immediate
//   ex_opcode, ex_func3       instruction fields
//   ex_pred_*                 BTB prediction carried with the instruction
//   redirect_valid/_pc        registered fetch redirect and flush request
//   btb_upd_*                 registered BTB update
//   branch_cnt/mispredict_cnt performance counters (tied to 0 unless BRANCH_PERF_CNT_EN is defined)
module ex_branch_resolve (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic        ex_forward_pipeline_flush,
  input  logic        ex_invalid_inst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic [31:0] ex_immediate,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_func3,
  input  logic        ex_pred_valid,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_predicted_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        btb_upd_valid,
  output logic        btb_upd_taken,
  output logic [31:0] btb_upd_pc,
  output logic [31:0] btb_upd_target,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);
  localparam logic [0:0] RESOLVE = 1'b0;
  localparam logic [0:0] SHADOW  = 1'b1;
  logic [0:0]  state_q, state_d;
  logic        is_br, is_jal, is_jalr, is_ctrl;
  logic        eq, lt_s, lt_u, br_taken, taken;
  logic [31:0] pc4, target, actual_pc, pred_pc, upd_target;
  logic        mispred, qual, do_redirect, do_upd;
  logic        redirect_valid_q, btb_upd_valid_q, btb_upd_taken_q;
  logic [31:0] redirect_pc_q, btb_upd_pc_q, btb_upd_target_q;
  always_comb begin
    is_br      = ex_opcode == 7'b1100011;
    is_jal     = ex_opcode == 7'b1101111;
    is_jalr    = ex_opcode == 7'b1100111;
    is_ctrl    = is_br | is_jal | is_jalr;
    eq         = ex_op1 == ex_op2;
    lt_s       = $signed(ex_op1) < $signed(ex_op2);
    lt_u       = ex_op1 < ex_op2;
    br_taken   = ex_func3 == 3'b000 ? eq :
                 ex_func3 == 3'b001 ? !eq :
                 ex_func3 == 3'b100 ? lt_s :
                 ex_func3 == 3'b101 ? !lt_s :
                 ex_func3 == 3'b110 ? lt_u :
                 ex_func3 == 3'b111 ? !lt_u : 1'b0;
    taken      = is_br ? br_taken : (is_jal | is_jalr);
    pc4        = ex_pc + 32'd4;
    target     = is_jalr ? ((ex_op1 + ex_immediate) & ~32'd1) : ex_pc + ex_immediate;
    actual_pc  = taken ? target : pc4;
    pred_pc    = (ex_pred_valid & ex_pred_taken) ? ex_predicted_pc : pc4;
    mispred    = pred_pc != actual_pc;
    qual       = pipeline_en & (state_q == RESOLVE) & !ex_forward_pipeline_flush & !ex_invalid_inst;
    do_redirect = qual & mispred;
    // a mispredicted non-control instruction is a BTB alias and is written back as not-taken
    do_upd     = qual & (is_ctrl | mispred);
    upd_target = is_ctrl ? target : pc4;
    // the instruction following a redirect is wrong-path until the pipeline advances once
    state_d    = state_q == RESOLVE ? (do_redirect ? SHADOW : RESOLVE) :
                 (pipeline_en ? RESOLVE : SHADOW);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RESOLVE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      btb_upd_valid_q  <= 1'b0;
      btb_upd_taken_q  <= 1'b0;
      btb_upd_pc_q     <= '0;
      btb_upd_target_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= do_redirect;
      redirect_pc_q    <= do_redirect ? actual_pc : redirect_pc_q;
      btb_upd_valid_q  <= do_upd;
      btb_upd_taken_q  <= do_upd ? taken : btb_upd_taken_q;
      btb_upd_pc_q     <= do_upd ? ex_pc : btb_upd_pc_q;
      btb_upd_target_q <= do_upd ? upd_target : btb_upd_target_q;
    end
  end
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign btb_upd_valid  = btb_upd_valid_q;
  assign btb_upd_taken  = btb_upd_taken_q;
  assign btb_upd_pc     = btb_upd_pc_q;
  assign btb_upd_target = btb_upd_target_q;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_q + {31'd0, qual & is_ctrl};
      mispredict_cnt_q <= mispredict_cnt_q + {31'd0, do_redirect};
    end
  end
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb_ex_branch_resolve: directed and randomized check of ex_branch_resolve against a behavioural model
module tb_ex_branch_resolve;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipeline_en = 1'b0, ex_forward_pipeline_flush = 1'b0, ex_invalid_inst = 1'b0;
  logic [31:0] ex_pc = '0, ex_op1 = '0, ex_op2 = '0, ex_immediate = '0, ex_predicted_pc = '0;
  logic [6:0]  ex_opcode = 7'b0010011;
  logic [2:0]  ex_func3 = '0;
  logic        ex_pred_valid = 1'b0, ex_pred_taken = 1'b0;
  logic        redirect_valid, btb_upd_valid, btb_upd_taken;
  logic [31:0] redirect_pc, btb_upd_pc, btb_upd_target, branch_cnt, mispredict_cnt;
  int checks = 0, passes = 0;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ADDI = 7'b0010011;

  ex_branch_resolve dut (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en),
    .ex_forward_pipeline_flush(ex_forward_pipeline_flush), .ex_invalid_inst(ex_invalid_inst),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_immediate(ex_immediate),
    .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_pred_valid(ex_pred_valid), .ex_pred_taken(ex_pred_taken), .ex_predicted_pc(ex_predicted_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_taken(btb_upd_taken),
    .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef BRANCH_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: what the registered outputs must hold after each rising edge
  logic        m_rv, m_bv, m_bt, wrong_path;
  logic [31:0] m_rpc, m_bpc, m_btgt, m_bc, m_mc;
  always @(posedge clk) begin
    logic        ctrl, tk, q;
    logic [31:0] tgt, act, pred;
    ctrl = 1'b0; tk = 1'b0; tgt = ex_pc + 32'd4;
    case (ex_opcode)
      BR: begin
        ctrl = 1'b1; tgt = ex_pc + ex_immediate;
        case (ex_func3)
          3'd0: tk = ex_op1 == ex_op2;
          3'd1: tk = ex_op1 != ex_op2;
          3'd4: tk = $signed(ex_op1) < $signed(ex_op2);
          3'd5: tk = $signed(ex_op1) >= $signed(ex_op2);
          3'd6: tk = ex_op1 < ex_op2;
          3'd7: tk = ex_op1 >= ex_op2;
          default: tk = 1'b0;
        endcase
      end
      JAL:  begin ctrl = 1'b1; tk = 1'b1; tgt = ex_pc + ex_immediate; end
      JALR: begin ctrl = 1'b1; tk = 1'b1; tgt = (ex_op1 + ex_immediate) & 32'hFFFF_FFFE; end
      default: ;
    endcase
    act  = tk ? tgt : ex_pc + 32'd4;
    pred = (ex_pred_valid && ex_pred_taken) ? ex_predicted_pc : ex_pc + 32'd4;
    q    = pipeline_en && !wrong_path && !ex_forward_pipeline_flush && !ex_invalid_inst;
    if (rst) begin
      {m_rv, m_bv, m_bt, wrong_path} = '0;
      {m_rpc, m_bpc, m_btgt, m_bc, m_mc} = '0;
    end else begin
      m_rv = 1'b0; m_bv = 1'b0;
      if (wrong_path && pipeline_en) wrong_path = 1'b0;
      else if (q) begin
        if (pred != act) begin
          m_rv = 1'b1; m_rpc = act; wrong_path = 1'b1; m_mc = m_mc + 1;
        end
        if (ctrl || pred != act) begin
          m_bv = 1'b1; m_bpc = ex_pc; m_bt = tk; m_btgt = ctrl ? tgt : ex_pc + 32'd4;
        end
        if (ctrl) m_bc = m_bc + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("btb_upd_valid", {31'd0, btb_upd_valid}, {31'd0, m_bv});
    chk("btb_upd_taken", {31'd0, btb_upd_taken}, {31'd0, m_bt});
    chk("btb_upd_pc", btb_upd_pc, m_bpc);
    chk("btb_upd_target", btb_upd_target, m_btgt);
    chk("branch_cnt", branch_cnt, cnt(m_bc));
    chk("mispredict_cnt", mispredict_cnt, cnt(m_mc));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic pv, input logic pt, input logic [31:0] ppc);
    ex_opcode = op; ex_func3 = f3; ex_pc = pc; ex_op1 = a; ex_op2 = b; ex_immediate = imm;
    ex_pred_valid = pv; ex_pred_taken = pt; ex_predicted_pc = ppc;
    ex_forward_pipeline_flush = 1'b0; ex_invalid_inst = 1'b0;
  endtask

  task automatic nop();
    issue(ADDI, 3'd0, 32'h0000_0800, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    nop();
    step(); step();
    chk("reset rv", {31'd0, redirect_valid}, 32'd0);
    chk("reset bv", {31'd0, btb_upd_valid}, 32'd0);
    chk("reset rpc", redirect_pc, 32'd0);
    chk("reset bc", branch_cnt, 32'd0);
    rst = 1'b0; pipeline_en = 1'b1;
    issue(BR, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 32'd0);
    step();
    chk("beq rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq rpc", redirect_pc, 32'h120);
    chk("beq btgt", btb_upd_target, 32'h120);
    chk("beq bt", {31'd0, btb_upd_taken}, 32'd1);
    chk("beq mc", mispredict_cnt, cnt(32'd1));
    chk("model beq rpc", m_rpc, 32'h120);
    nop(); step();
    issue(BR, 3'd1, 32'h200, 32'd7, 32'd7, 32'h40, 1'b1, 1'b1, 32'h240);
    step();
    chk("bne rv", {31'd0, redirect_valid}, 32'd1);
    chk("bne rpc", redirect_pc, 32'h204);
    chk("bne bt", {31'd0, btb_upd_taken}, 32'd0);
    chk("model bne rpc", m_rpc, 32'h204);
    issue(JAL, 3'd0, 32'h500, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 32'd0);
    step();
    chk("shadow rv", {31'd0, redirect_valid}, 32'd0);
    chk("shadow bv", {31'd0, btb_upd_valid}, 32'd0);
    chk("shadow bc", branch_cnt, cnt(32'd2));
    issue(JALR, 3'd0, 32'h600, 32'h1001, 32'd0, 32'h2, 1'b1, 1'b1, 32'h1002);
    step();
    chk("jalr rv", {31'd0, redirect_valid}, 32'd0);
    chk("jalr bv", {31'd0, btb_upd_valid}, 32'd1);
    chk("jalr btgt", btb_upd_target, 32'h1002);
    chk("jalr rpc hold", redirect_pc, 32'h204);
    chk("jalr bc", branch_cnt, cnt(32'd3));
    issue(BR, 3'd4, 32'h700, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b0, 32'd0);
    pipeline_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall rv", {31'd0, redirect_valid}, 32'd0);
      chk("stall bc", branch_cnt, cnt(32'd3));
    end
    pipeline_en = 1'b1;
    step();
    chk("blt rv", {31'd0, redirect_valid}, 32'd1);
    chk("blt rpc", redirect_pc, 32'h710);
    chk("blt bc", branch_cnt, cnt(32'd4));
    nop(); step();
    chk("blt single pulse", {31'd0, redirect_valid}, 32'd0);
    chk("blt counted once", branch_cnt, cnt(32'd4));
    issue(ADDI, 3'd0, 32'h300, 32'd0, 32'd0, 32'h5, 1'b1, 1'b1, 32'h400);
    step();
    chk("alias rv", {31'd0, redirect_valid}, 32'd1);
    chk("alias rpc", redirect_pc, 32'h304);
    chk("alias bt", {31'd0, btb_upd_taken}, 32'd0);
    chk("alias btgt", btb_upd_target, 32'h304);
    chk("alias bc", branch_cnt, cnt(32'd4));
    chk("alias mc", mispredict_cnt, cnt(32'd4));
    pipeline_en = 1'b0; step();
    rst = 1'b1; step();
    chk("rst shadow rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst shadow rpc", redirect_pc, 32'd0);
    chk("rst shadow btgt", btb_upd_target, 32'd0);
    chk("rst shadow mc", mispredict_cnt, 32'd0);
    rst = 1'b0; pipeline_en = 1'b1;
    issue(BR, 3'd0, 32'h100, 32'd9, 32'd9, 32'h20, 1'b0, 1'b0, 32'd0);
    step();
    chk("post rst resolve", {31'd0, redirect_valid}, 32'd1);
    chk("post rst bc", branch_cnt, cnt(32'd1));
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] pc, imm, a;
      pc = $urandom & 32'hFFFF_FFFC; imm = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h0000_0FFE);
      a = $urandom;
      case ($urandom_range(0, 5))
        0, 1: ex_opcode = BR;
        2: ex_opcode = JAL;
        3: ex_opcode = JALR;
        4: ex_opcode = ADDI;
        default: ex_opcode = 7'($urandom);
      endcase
      ex_func3 = 3'($urandom); ex_pc = pc; ex_immediate = imm; ex_op1 = a;
      ex_op2 = $urandom_range(0, 2) == 0 ? a : ($urandom_range(0, 1) == 0 ? $urandom : a ^ 32'h8000_0000);
      ex_pred_valid = $urandom_range(0, 2) != 0; ex_pred_taken = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: ex_predicted_pc = pc + imm;
        1: ex_predicted_pc = pc + 32'd4;
        2: ex_predicted_pc = (a + imm) & 32'hFFFF_FFFE;
        default: ex_predicted_pc = $urandom;
      endcase
      pipeline_en = $urandom_range(0, 3) != 0;
      ex_forward_pipeline_flush = $urandom_range(0, 9) == 0;
      ex_invalid_inst = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 1'b0;
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
